alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter that shares the single register-file/ALU datapath between two requesters (requester 0: main decode path; requester 1: loader/debug port). It accepts one operation per cycle over a valid/ready handshake, registers the granted operation into an issue stage that drives the datapath control and address inputs, and returns the datapath EQ flag to the owning requester one cycle later. A per-requester lock input permits bounded back-to-back bursts.

## Interface
- A_WIDTH, 5, register address width
- D_WIDTH, 32, immediate width
- CTRL_WIDTH, 3, ALU control width
- MAX_BURST, 4, maximum consecutive grants to a locked requester (≥1)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  global stall; no acceptance while high
- reqN_valid  in  1  (N=0,1) operation presented
- reqN_ready  out  1  operation accepted this cycle
- reqN_lock  in  1  request to retain grant next cycle
- reqN_alusrc  in  1  operand-2 select (1 = immediate)
- reqN_aluctrl  in  CTRL_WIDTH  ALU operation
- reqN_regwrite  in  1  write result to rd
- reqN_rs1, reqN_rs2, reqN_rd  in  A_WIDTH each  register addresses
- reqN_imm  in  D_WIDTH  immediate operand
- dp_alusrc  out  1  to datapath
- dp_aluctrl  out  CTRL_WIDTH  to datapath
- dp_regwrite  out  1  to datapath write enable
- dp_rs1, dp_rs2, dp_rd  out  A_WIDTH  to datapath
- dp_imm  out  D_WIDTH  to datapath
- dp_eq  in  1  EQ flag from datapath (combinational from dp_* inputs)
- rspN_valid  out  1  response for requester N
- rsp_eq  out  1  captured EQ for the responding requester

## Operation
- Arbitration (combinational): prio pointer P ∈ {0,1}. If hold=1: both ready=0. Else if only one valid: that one ready. If both valid: requester P ready. At most one ready ever high.
- Pointer update on accept from requester i: if reqi_lock=1 and burst_cnt < MAX_BURST-1 → P=i, burst_cnt+1; else P=1-i, burst_cnt=0. Accept from a different requester than the previous accept resets burst_cnt to 1 if locking, else 0. No accept: P and burst_cnt unchanged.
- Issue stage: on accept, all reqi_* fields latched into dp_*, owner id and issue_v=1 registered. No accept: issue_v=0, dp_regwrite=0, other dp_* hold last values.
- dp_regwrite = latched regwrite AND issue_v; never high on a bubble.
- Response stage: issue_v=1 → next cycle rsp{owner}_valid=1, rsp_eq=dp_eq sampled at that edge. Otherwise both rsp valid=0, rsp_eq holds.
- Responses have no backpressure; requesters must sink them.
- No hazard checking; requesters responsible for ordering among themselves.

## Timing
- Reset (async assert, sync-safe deassert): P=0, burst_cnt=0, issue_v=0, all dp_* = 0, rsp0_valid=rsp1_valid=0, rsp_eq=0; readies follow combinational rule (hold/valid) immediately.
- Cycle N accept → cycle N+1 dp_* driven (register write commits at end of N+1) → cycle N+2 rspN_valid, rsp_eq.
- Throughput: one op per cycle sustained; a lone requester is granted every cycle.
- hold rising mid-stream: ops already accepted still issue and respond; new accepts stop that cycle.
- Reset mid-operation: in-flight issue and response discarded; no spurious dp_regwrite after release.
- MAX_BURST=1: lock has no effect (strict alternation when both valid).

## Test plan
- Reset: rst_n=0 while both valid → all dp_* 0, rsp valids 0; release → req0 granted first.
- Both valid continuously, no lock, 6 cycles → grants 0,1,0,1,0,1; rsp0_valid/rsp1_valid alternate starting 2 cycles after first accept.
- req1 lock=1 with both valid, MAX_BURST=4, P=1 → req1 granted 4 consecutive cycles, then req0.
- req0 op rs1=3, rs2=3, regwrite=1 with dp_eq model returning 1 → dp_regwrite high exactly in cycle N+1, rsp0_valid=1 and rsp_eq=1 in N+2.
- hold=1 for 3 cycles with both valid → no ready, dp_regwrite=0 after in-flight drains; first grant after hold goes to pre-hold P.
- Assert rst_n=0 in cycle N+1 of an accepted regwrite op → dp_regwrite drops immediately, no rsp_valid after release.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one register-file/ALU datapath between two requesters,
// with an issue register stage, a one-cycle EQ response stage and lock-driven bursts.
module alu_arbiter #(
  parameter int A_WIDTH    = 5,
  parameter int D_WIDTH    = 32,
  parameter int CTRL_WIDTH = 3,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_lock,
  input  logic                  req0_alusrc,
  input  logic [CTRL_WIDTH-1:0] req0_aluctrl,
  input  logic                  req0_regwrite,
  input  logic [A_WIDTH-1:0]    req0_rs1,
  input  logic [A_WIDTH-1:0]    req0_rs2,
  input  logic [A_WIDTH-1:0]    req0_rd,
  input  logic [D_WIDTH-1:0]    req0_imm,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_lock,
  input  logic                  req1_alusrc,
  input  logic [CTRL_WIDTH-1:0] req1_aluctrl,
  input  logic                  req1_regwrite,
  input  logic [A_WIDTH-1:0]    req1_rs1,
  input  logic [A_WIDTH-1:0]    req1_rs2,
  input  logic [A_WIDTH-1:0]    req1_rd,
  input  logic [D_WIDTH-1:0]    req1_imm,

  output logic                  dp_alusrc,
  output logic [CTRL_WIDTH-1:0] dp_aluctrl,
  output logic                  dp_regwrite,
  output logic [A_WIDTH-1:0]    dp_rs1,
  output logic [A_WIDTH-1:0]    dp_rs2,
  output logic [A_WIDTH-1:0]    dp_rd,
  output logic [D_WIDTH-1:0]    dp_imm,
  input  logic                  dp_eq,

  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  output logic                  rsp_eq
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_BURST - 1);

  typedef enum logic {PRIO_0 = 1'b0, PRIO_1 = 1'b1} prio_t;

  prio_t          prio, prio_nxt;
  logic [CW-1:0]  burst_cnt, burst_cnt_nxt, burst_base;
  logic           last_owner;
  logic           accept, sel, sel_lock;

  logic                  regwrite_q;
  logic                  issue_v;
  logic                  owner;

  // Combinational grant: hold blocks everything, contention resolved by prio.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!hold) begin
      if (req0_valid && req1_valid) begin
        if (prio == PRIO_0) req0_ready = 1'b1;
        else                req1_ready = 1'b1;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign accept   = req0_ready | req1_ready;
  assign sel      = req1_ready;
  assign sel_lock = sel ? req1_lock : req0_lock;

  // A burst only continues counting while the same requester keeps winning.
  always_comb begin
    prio_nxt      = prio;
    burst_cnt_nxt = burst_cnt;
    burst_base    = (last_owner == sel) ? burst_cnt : '0;
    if (accept) begin
      if (sel_lock && (burst_base < BURST_LIMIT)) begin
        prio_nxt      = sel ? PRIO_1 : PRIO_0;
        burst_cnt_nxt = burst_base + 1'b1;
      end else begin
        prio_nxt      = sel ? PRIO_0 : PRIO_1;
        burst_cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio       <= PRIO_0;
      burst_cnt  <= '0;
      last_owner <= 1'b0;
    end else begin
      prio      <= prio_nxt;
      burst_cnt <= burst_cnt_nxt;
      if (accept) last_owner <= sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_v    <= 1'b0;
      owner      <= 1'b0;
      regwrite_q <= 1'b0;
      dp_alusrc  <= 1'b0;
      dp_aluctrl <= '0;
      dp_rs1     <= '0;
      dp_rs2     <= '0;
      dp_rd      <= '0;
      dp_imm     <= '0;
    end else begin
      issue_v <= accept;
      if (accept) begin
        owner      <= sel;
        regwrite_q <= sel ? req1_regwrite : req0_regwrite;
        dp_alusrc  <= sel ? req1_alusrc   : req0_alusrc;
        dp_aluctrl <= sel ? req1_aluctrl  : req0_aluctrl;
        dp_rs1     <= sel ? req1_rs1      : req0_rs1;
        dp_rs2     <= sel ? req1_rs2      : req0_rs2;
        dp_rd      <= sel ? req1_rd       : req0_rd;
        dp_imm     <= sel ? req1_imm      : req0_imm;
      end
    end
  end

  // Gating with issue_v keeps the write enable low on bubbles and right after reset.
  assign dp_regwrite = regwrite_q & issue_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_eq     <= 1'b0;
    end else begin
      rsp0_valid <= issue_v & ~owner;
      rsp1_valid <= issue_v &  owner;
      if (issue_v) rsp_eq <= dp_eq;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, alternation, lock bursts, EQ response,
// hold behaviour and reset during an in-flight write.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, hold;
  logic        req0_valid, req0_ready, req0_lock, req0_alusrc, req0_regwrite;
  logic [2:0]  req0_aluctrl;
  logic [4:0]  req0_rs1, req0_rs2, req0_rd;
  logic [31:0] req0_imm;
  logic        req1_valid, req1_ready, req1_lock, req1_alusrc, req1_regwrite;
  logic [2:0]  req1_aluctrl;
  logic [4:0]  req1_rs1, req1_rs2, req1_rd;
  logic [31:0] req1_imm;
  logic        dp_alusrc, dp_regwrite, dp_eq;
  logic [2:0]  dp_aluctrl;
  logic [4:0]  dp_rs1, dp_rs2, dp_rd;
  logic [31:0] dp_imm;
  logic        rsp0_valid, rsp1_valid, rsp_eq;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  // Stand-in datapath: EQ when both source addresses match.
  assign dp_eq = (dp_rs1 == dp_rs2);

  alu_arbiter #(.A_WIDTH(5), .D_WIDTH(32), .CTRL_WIDTH(3), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_lock(req0_lock),
    .req0_alusrc(req0_alusrc), .req0_aluctrl(req0_aluctrl), .req0_regwrite(req0_regwrite),
    .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_rd(req0_rd), .req0_imm(req0_imm),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_lock(req1_lock),
    .req1_alusrc(req1_alusrc), .req1_aluctrl(req1_aluctrl), .req1_regwrite(req1_regwrite),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_rd(req1_rd), .req1_imm(req1_imm),
    .dp_alusrc(dp_alusrc), .dp_aluctrl(dp_aluctrl), .dp_regwrite(dp_regwrite),
    .dp_rs1(dp_rs1), .dp_rs2(dp_rs2), .dp_rd(dp_rd), .dp_imm(dp_imm), .dp_eq(dp_eq),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_eq(rsp_eq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0;
    req0_valid = 1'b1; req0_lock = 1'b0; req0_alusrc = 1'b0; req0_aluctrl = 3'd1;
    req0_regwrite = 1'b1; req0_rs1 = 5'd1; req0_rs2 = 5'd2; req0_rd = 5'd3; req0_imm = 32'h100;
    req1_valid = 1'b1; req1_lock = 1'b0; req1_alusrc = 1'b1; req1_aluctrl = 3'd2;
    req1_regwrite = 1'b0; req1_rs1 = 5'd4; req1_rs2 = 5'd5; req1_rd = 5'd6; req1_imm = 32'h200;

    // Reset with both requesters valid
    #3;
    check("rst_dp_regwrite", dp_regwrite, 0);
    check("rst_dp_rs1", dp_rs1, 0);
    check("rst_dp_rd", dp_rd, 0);
    check("rst_dp_imm", dp_imm, 0);
    check("rst_dp_aluctrl", dp_aluctrl, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_rsp_eq", rsp_eq, 0);
    check("rst_ready0", req0_ready, 1);
    check("rst_ready1", req1_ready, 0);
    tick();
    tick();
    check("rst_hold_dp_rs1", dp_rs1, 0);
    rst_n = 1'b1;
    #1;

    // Both valid, no lock: strict alternation starting with req0
    for (int k = 0; k < 6; k++) begin
      check("alt_ready0", req0_ready, (k % 2 == 0));
      check("alt_ready1", req1_ready, (k % 2 == 1));
      tick();
      check("alt_dp_rs1", dp_rs1, (k % 2 == 0) ? 32'd1 : 32'd4);
      check("alt_dp_regwrite", dp_regwrite, (k % 2 == 0));
      if (k > 0) begin
        check("alt_rsp0_valid", rsp0_valid, ((k - 1) % 2 == 0));
        check("alt_rsp1_valid", rsp1_valid, ((k - 1) % 2 == 1));
        check("alt_rsp_eq", rsp_eq, 0);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("bubble_dp_regwrite", dp_regwrite, 0);
    check("bubble_dp_rs1_hold", dp_rs1, 4);
    check("last_rsp1_valid", rsp1_valid, 1);
    check("last_rsp0_valid", rsp0_valid, 0);
    tick();
    check("idle_rsp0_valid", rsp0_valid, 0);
    check("idle_rsp1_valid", rsp1_valid, 0);

    // Move prio to req1, then a locked req1 burst of MAX_BURST grants
    req0_valid = 1'b1;
    #1;
    check("lone_ready0", req0_ready, 1);
    tick();
    req1_valid = 1'b1; req1_lock = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("burst_ready1", req1_ready, 1);
      check("burst_ready0", req0_ready, 0);
      tick();
    end
    check("burst_end_ready0", req0_ready, 1);
    check("burst_end_ready1", req1_ready, 0);
    req1_lock = 1'b0;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    tick();

    // req0 op with matching sources: EQ returned two cycles after accept
    req0_rs1 = 5'd3; req0_rs2 = 5'd3; req0_valid = 1'b1;
    #1;
    check("eq_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    check("eq_n1_dp_regwrite", dp_regwrite, 1);
    check("eq_n1_dp_rs1", dp_rs1, 3);
    check("eq_n1_dp_imm", dp_imm, 32'h100);
    check("eq_n1_rsp0_valid", rsp0_valid, 0);
    tick();
    check("eq_n2_dp_regwrite", dp_regwrite, 0);
    check("eq_n2_rsp0_valid", rsp0_valid, 1);
    check("eq_n2_rsp1_valid", rsp1_valid, 0);
    check("eq_n2_rsp_eq", rsp_eq, 1);
    tick();
    check("eq_n3_rsp0_valid", rsp0_valid, 0);
    check("eq_n3_rsp_eq_hold", rsp_eq, 1);
    req0_rs1 = 5'd1; req0_rs2 = 5'd2;

    // Hold for 3 cycles right after a req1 regwrite accept
    req1_regwrite = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("prehold_ready1", req1_ready, 1);
    tick();
    hold = 1'b1;
    #1;
    check("hold_inflight_regwrite", dp_regwrite, 1);
    check("hold_ready0", req0_ready, 0);
    check("hold_ready1", req1_ready, 0);
    tick();
    check("hold_drain_regwrite", dp_regwrite, 0);
    check("hold_rsp1_valid", rsp1_valid, 1);
    check("hold_ready0_b", req0_ready, 0);
    tick();
    check("hold_ready1_c", req1_ready, 0);
    tick();
    check("hold_ready0_d", req0_ready, 0);
    check("hold_rsp1_idle", rsp1_valid, 0);
    hold = 1'b0;
    #1;
    check("posthold_ready0", req0_ready, 1);
    check("posthold_ready1", req1_ready, 0);
    tick();
    check("posthold_dp_rs1", dp_rs1, 1);
    req0_valid = 1'b0; req1_valid = 1'b0; req1_regwrite = 1'b0;
    tick();
    tick();

    // Reset while an accepted regwrite op sits in the issue stage
    req0_valid = 1'b1;
    #1;
    tick();
    req0_valid = 1'b0;
    check("rmid_dp_regwrite", dp_regwrite, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rmid_regwrite_drop", dp_regwrite, 0);
    check("rmid_dp_rd", dp_rd, 0);
    tick();
    check("rmid_rsp0_in_reset", rsp0_valid, 0);
    rst_n = 1'b1;
    #1;
    tick();
    check("rmid_rsp0_after", rsp0_valid, 0);
    check("rmid_regwrite_after", dp_regwrite, 0);
    tick();
    check("rmid_rsp0_after2", rsp0_valid, 0);
    check("rmid_rsp1_after2", rsp1_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
